// File: rtl/bmem_arbiter_pkg.sv
// Shared types and constants for the burst-memory arbiter.
package bmem_arbiter_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned LINE_W         = 256;
  localparam int unsigned BEAT_W         = 64;
  localparam int unsigned BEATS_PER_LINE = LINE_W / BEAT_W;
  localparam int unsigned CNT_W          = $clog2(BEATS_PER_LINE);
  localparam int unsigned LINE_BYTES     = LINE_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_RESP
  } bmem_arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

  // Clear the byte-within-line offset bits.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/bmem_arbiter_line_beat_buffer.sv
// One cache line of storage, loadable whole or beat-by-beat, plus the beat counter.
module line_beat_buffer
  import bmem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_we,
  input  logic [BEAT_W-1:0] beat_wdata,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  output logic [CNT_W-1:0]  cnt,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] beat_rdata
);

  // Line storage: whole-line load for writebacks, indexed beat fill for reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line <= '0;
    end else if (load) begin
      line <= load_line;
    end else if (beat_we) begin
      line[BEAT_W*int'(cnt) +: BEAT_W] <= beat_wdata;
    end
  end

  // Beat counter, wraps naturally after the last beat of a line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Current beat selected by the counter.
  always_comb begin
    beat_rdata = line[BEAT_W*int'(cnt) +: BEAT_W];
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter sharing the burst-memory port between I-side and D-side line misses.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  bmem_arb_state_t   state_q, state_d;
  side_t             gnt_q, last_q, pick;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] i_hold_q, d_hold_q;
  line_req_t         req_sel;
  logic              grant, load, beat_we, cnt_clr, cnt_inc, last_beat;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat_rdata;

  line_beat_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_line  (req_sel.wdata),
    .beat_we    (beat_we),
    .beat_wdata (bmem_rdata),
    .cnt_clr    (cnt_clr),
    .cnt_inc    (cnt_inc),
    .cnt        (cnt),
    .line       (line),
    .beat_rdata (beat_rdata)
  );

  assign last_beat = (cnt == CNT_W'(BEATS_PER_LINE - 1));

  // Round-robin side selection and the request bundle of the winning side.
  always_comb begin
    pick = SIDE_I;
    if (i_read && (d_read || d_write)) begin
      pick = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
    end else if (d_read || d_write) begin
      pick = SIDE_D;
    end
    req_sel = '0;
    if (pick == SIDE_D) begin
      req_sel.addr  = d_addr;
      req_sel.read  = d_read;
      req_sel.write = d_write;
      req_sel.wdata = d_wdata;
    end else begin
      req_sel.addr = i_addr;
      req_sel.read = i_read;
    end
  end

  // Next-state logic and buffer controls.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    load    = 1'b0;
    beat_we = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (i_read || d_read || d_write) begin
          grant = 1'b1;
          if (req_sel.read) begin
            state_d = ST_RD_REQ;
          end else begin
            state_d = ST_WR_DATA;
            load    = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        if (bmem_ready) begin
          state_d = ST_RD_DATA;
          cnt_clr = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (bmem_rvalid) begin
          beat_we = 1'b1;
          cnt_inc = 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_WR_DATA: begin
        if (bmem_ready) begin
          cnt_inc = 1'b1;
          if (last_beat) state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus latched grant, address and direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= SIDE_I;
      last_q  <= SIDE_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_q  <= pick;
        wr_q   <= req_sel.write;
        addr_q <= line_align(req_sel.addr);
      end
      if (state_q == ST_RESP) last_q <= gnt_q;
    end
  end

  // Per-side copies so each rdata output holds its last fill line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else if (state_q == ST_RESP && !wr_q) begin
      if (gnt_q == SIDE_I) i_hold_q <= line;
      else                 d_hold_q <= line;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    i_resp     = (state_q == ST_RESP) && (gnt_q == SIDE_I);
    d_resp     = (state_q == ST_RESP) && (gnt_q == SIDE_D);
    i_rdata    = (i_resp && !wr_q) ? line : i_hold_q;
    d_rdata    = (d_resp && !wr_q) ? line : d_hold_q;
    bmem_read  = (state_q == ST_RD_REQ);
    bmem_write = (state_q == ST_WR_DATA);
    bmem_wdata = bmem_write ? beat_rdata : '0;
    bmem_addr  = (state_q == ST_RD_REQ || state_q == ST_RD_DATA || state_q == ST_WR_DATA)
                 ? addr_q : '0;
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
  a_raddr:    assert property (@(posedge clk) disable iff (rst)
                (bmem_rvalid && state_q == ST_RD_DATA) |-> (bmem_raddr == addr_q));
  a_rvalid:   assert property (@(posedge clk) disable iff (rst)
                bmem_rvalid |-> (state_q == ST_RD_DATA));

endmodule

// File: tb/tb_bmem_arbiter.sv
// Randomized bench for bmem_arbiter with a transaction-level reference model.
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic [31:0]  d_addr;
  logic         d_read, d_write;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  // side: 0 = I, 1 = D
  typedef struct {
    bit           side;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t         i_q[$], d_q[$], cur;
  bit           busy, rd_active, last_side, prev_resp;
  int           rd_idx;
  int           errors = 0, checks = 0, stepn = 0;
  int           grant_step, resp_step, last_wbeat_step;
  int           ready_pct, valid_pct, stall_beat, stall_left;
  logic [63:0]  fixed_beats[$], wcap[$];
  logic [255:0] exp_line, last_i_line;
  logic [31:0]  first_addr;
  bit           first_addr_seen;
  bit           order[$];

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic bit outs_zero();
    return ({i_resp, i_rdata, d_resp, d_rdata, bmem_addr, bmem_read, bmem_write, bmem_wdata} === '0);
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the side not served last wins.
  function automatic bit pick_side(bit ireq, bit dreq, bit last);
    if (ireq && dreq) return !last;
    return dreq;
  endfunction

  // One clock cycle: observe DUT outputs, check against the model, then drive inputs.
  task automatic step();
    bit resp_now, got_side, stall;
    @(posedge clk);
    #1;
    stepn++;
    resp_now = (i_resp === 1'b1) || (d_resp === 1'b1);

    if (prev_resp) begin
      checks++;
      if (resp_now) begin
        errors++;
        $display("FAIL resp_width: resp still high (i=%b d=%b), required one-cycle pulse", i_resp, d_resp);
      end
    end else if (resp_now && !busy) begin
      checks++;
      errors++;
      $display("FAIL spurious_resp: i_resp=%b d_resp=%b with no transaction outstanding", i_resp, d_resp);
    end else if (resp_now) begin
      checks++;
      got_side = (d_resp === 1'b1);
      if ((i_resp === 1'b1 && d_resp === 1'b1) || got_side !== cur.side) begin
        errors++;
        $display("FAIL grant_side: i_resp=%b d_resp=%b, required side %0d", i_resp, d_resp, cur.side);
      end
      checks++;
      if (!cur.wr) begin
        if ((cur.side ? d_rdata : i_rdata) !== exp_line) begin
          errors++;
          $display("FAIL rdata: got %h required %h", cur.side ? d_rdata : i_rdata, exp_line);
        end
        if (!cur.side) last_i_line = exp_line;
      end else if (wcap.size() != 4 || {wcap[3], wcap[2], wcap[1], wcap[0]} !== cur.wdata) begin
        errors++;
        $display("FAIL wbeats: %0d beats captured, required 4 beats of %h", wcap.size(), cur.wdata);
      end
      busy      = 1'b0;
      resp_step = stepn;
    end else if (busy && stepn == grant_step + 1) begin
      checks++;
      if ((cur.wr ? bmem_write : bmem_read) !== 1'b1) begin
        errors++;
        $display("FAIL start_latency: read=%b write=%b, required %s the cycle after grant",
                 bmem_read, bmem_write, cur.wr ? "write" : "read");
      end
    end
    prev_resp = resp_now;

    if (busy && (bmem_read === 1'b1 || bmem_write === 1'b1)) begin
      checks++;
      if (!first_addr_seen) begin
        first_addr      = bmem_addr;
        first_addr_seen = 1'b1;
      end
      if (bmem_addr !== (cur.addr & 32'hFFFF_FFE0)) begin
        errors++;
        $display("FAIL bmem_addr: got %h required %h", bmem_addr, cur.addr & 32'hFFFF_FFE0);
      end
    end

    // Memory side.
    bmem_rvalid = 1'b0;
    bmem_ready  = 1'b0;
    bmem_raddr  = cur.addr & 32'hFFFF_FFE0;
    if (rd_active) begin
      if ($urandom_range(99) < valid_pct) begin
        bmem_rdata  = (fixed_beats.size() != 0) ? fixed_beats.pop_front() : {$urandom, $urandom};
        bmem_rvalid = 1'b1;
        exp_line[rd_idx*64 +: 64] = bmem_rdata;
        rd_idx++;
        if (rd_idx == 4) rd_active = 1'b0;
      end
    end else if (bmem_read === 1'b1) begin
      bmem_ready = ($urandom_range(99) < ready_pct);
      if (bmem_ready) begin
        rd_active = 1'b1;
        rd_idx    = 0;
      end
    end else if (bmem_write === 1'b1) begin
      stall = (wcap.size() == stall_beat) && (stall_left > 0);
      if (stall) begin
        stall_left--;
        checks++;
        if (bmem_wdata !== cur.wdata[stall_beat*64 +: 64]) begin
          errors++;
          $display("FAIL stall_hold: wdata %h required %h", bmem_wdata, cur.wdata[stall_beat*64 +: 64]);
        end
      end else begin
        bmem_ready = ($urandom_range(99) < ready_pct);
        if (bmem_ready) begin
          wcap.push_back(bmem_wdata);
          last_wbeat_step = stepn;
        end
      end
    end

    // Requesters: hold until resp, drop on resp, raise when work is queued.
    if (i_resp === 1'b1) begin
      i_read = 1'b0;
      void'(i_q.pop_front());
    end else if (!i_read && i_q.size() != 0) begin
      i_read = 1'b1;
      i_addr = i_q[0].addr;
    end
    if (d_resp === 1'b1) begin
      d_read  = 1'b0;
      d_write = 1'b0;
      void'(d_q.pop_front());
    end else if (!d_read && !d_write && d_q.size() != 0) begin
      d_addr  = d_q[0].addr;
      d_wdata = d_q[0].wdata;
      d_read  = !d_q[0].wr;
      d_write = d_q[0].wr;
    end

    // Model grant decision for the requests now presented.
    if (!busy && !resp_now && (i_read || d_read || d_write)) begin
      got_side   = pick_side(i_read, d_read || d_write, last_side);
      cur        = got_side ? d_q[0] : i_q[0];
      last_side  = got_side;
      busy       = 1'b1;
      grant_step = stepn;
      exp_line   = 'x;
      wcap.delete();
      order.push_back(got_side);
    end
  endtask

  task automatic run(input int max_steps, input string name);
    int n = 0;
    while ((busy || i_q.size() != 0 || d_q.size() != 0) && n < max_steps) begin
      step();
      n++;
    end
    checks++;
    if (n >= max_steps) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required completion", name, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = '0; bmem_rdata = '0;
    busy = 0; rd_active = 0; rd_idx = 0; last_side = 0; prev_resp = 0;
    i_q.delete(); d_q.delete(); order.delete(); fixed_beats.delete(); wcap.delete();
    stall_beat = -1; stall_left = 0; ready_pct = 100; valid_pct = 100;
    cur = '{0, 0, '0, '0};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL in_reset: outputs not zero (read=%b write=%b addr=%h), required all zero",
               bmem_read, bmem_write, bmem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (!outs_zero()) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d outputs not zero (read=%b write=%b)", c, bmem_read, bmem_write);
      end
    end
  endtask

  task automatic test_i_read();
    fixed_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                    64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    last_i_line     = '0;
    first_addr_seen = 1'b0;
    i_q.push_back('{0, 0, 32'h0000_1024, '0});
    run(100, "i_read");
    checks++;
    if (first_addr !== 32'h0000_1020) begin
      errors++;
      $display("FAIL i_read_addr: got %h required 00001020", first_addr);
    end
    checks++;
    if (last_i_line !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++;
      $display("FAIL i_read_line: got %h", last_i_line);
    end
    repeat (3) step();
    checks++;
    if (i_rdata !== last_i_line) begin
      errors++;
      $display("FAIL rdata_hold: got %h required %h", i_rdata, last_i_line);
    end
  endtask

  task automatic test_write_zero_wait();
    d_q.push_back('{1, 1, 32'h0000_2000 | 32'($urandom_range(31)), rand_line()});
    run(100, "write_zero_wait");
    checks++;
    if (resp_step - grant_step != 5) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles after request, required 5", resp_step - grant_step);
    end
  endtask

  task automatic test_write_stall();
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = 64'hDDCC_BBAA_0000_0000 | 64'(k + 1);
    stall_beat = 2;
    stall_left = 2;
    d_q.push_back('{1, 1, 32'h8000_0040, l});
    run(100, "write_stall");
    checks++;
    if (resp_step - grant_step != 7) begin
      errors++;
      $display("FAIL stall_latency: got %0d cycles after request, required 7", resp_step - grant_step);
    end
    checks++;
    if (resp_step != last_wbeat_step + 1) begin
      errors++;
      $display("FAIL resp_after_last_beat: resp at %0d, last beat at %0d", resp_step, last_wbeat_step);
    end
    stall_beat = -1;
  endtask

  task automatic test_dual_after_reset();
    do_reset();
    valid_pct = 70;
    i_q.push_back('{0, 0, 32'h0000_3000, '0});
    d_q.push_back('{1, 0, 32'h0000_4008, '0});
    run(200, "dual");
    checks++;
    if (order.size() != 2 || order[0] != 1'b1 || order[1] != 1'b0) begin
      errors++;
      $display("FAIL dual_order: %0d grants, first=%0d, required D then I", order.size(),
               order.size() > 0 ? order[0] : 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    ready_pct = 80;
    valid_pct = 75;
    order.delete();
    for (int k = 0; k < 3; k++) begin
      i_q.push_back('{0, 0, $urandom, '0});
      d_q.push_back('{1, bit'(k % 2), $urandom, rand_line()});
    end
    run(2000, "back_to_back");
    checks++;
    if (order.size() != 6) begin
      errors++;
      $display("FAIL fair_count: %0d grants, required 6", order.size());
    end
    for (int k = 1; k < order.size(); k++) begin
      checks++;
      if (order[k] == order[k-1]) begin
        errors++;
        $display("FAIL fair_alternate: grant %0d side %0d repeats previous", k, order[k]);
      end
    end
  endtask

  task automatic test_random();
    order.delete();
    for (int k = 0; k < 24; k++) begin
      ready_pct = $urandom_range(100, 40);
      valid_pct = $urandom_range(100, 40);
      if ($urandom_range(1)) i_q.push_back('{0, 0, $urandom, '0});
      else                   d_q.push_back('{1, bit'($urandom_range(1)), $urandom, rand_line()});
      if ($urandom_range(2) == 0) run(400, "random");
    end
    run(8000, "random");
    checks++;
    if (order.size() != 24) begin
      errors++;
      $display("FAIL random_count: %0d grants, required 24", order.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    ready_pct = 100;
    valid_pct = 100;
    i_q.push_back('{0, 0, 32'h0000_5040, '0});
    while (!(rd_active && rd_idx == 2) && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL midburst_setup_timeout: read burst never reached beat 2");
    end
    @(posedge clk);
    #1;
    bmem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (!outs_zero()) begin
      errors++;
      $display("FAIL midburst_reset_outputs: outputs not zero (i_resp=%b read=%b addr=%h)", i_resp, bmem_read, bmem_addr);
    end
    do_reset();
    repeat (5) step();
    order.delete();
    i_q.push_back('{0, 0, 32'h0000_6000, '0});
    run(100, "after_midburst");
    checks++;
    if (order.size() != 1 || order[0] != 1'b0) begin
      errors++;
      $display("FAIL after_midburst: %0d grants, required one I grant", order.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_write_zero_wait();
    test_write_stall();
    test_dual_after_reset();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
